// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI slave-side responder.
// Optional illegal-strobe counter is enabled by defining HPI_RESP_ERRCNT_EN.
package hpi_pkg;

  typedef enum logic [1:0] {
    HPI_DATA    = 2'd0,
    HPI_MAILBOX = 2'd1,
    HPI_ADDRESS = 2'd2,
    HPI_STATUS  = 2'd3
  } hpi_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE_DONE
  } hpi_state_e;

  localparam int STAT_OUT_FULL_BIT  = 0;
  localparam int STAT_IN_VALID_BIT  = 1;

  function automatic logic rising_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic [15:0] status_word(input logic in_valid, input logic out_full);
    logic [15:0] s;
    s = '0;
    s[STAT_IN_VALID_BIT] = in_valid;
    s[STAT_OUT_FULL_BIT] = out_full;
    return s;
  endfunction

endpackage

// File: rtl/hpi_strobe_sync.sv
// Synchronizer chain for all OTG inputs plus start/end edge detection of the
// read, write and illegal-strobe conditions.
module hpi_strobe_sync
  import hpi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n_i,
  input  logic        rd_n_i,
  input  logic        wr_n_i,
  input  logic        rst_n_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] data_i,
  output logic        rst_n_o,
  output logic [1:0]  addr_o,
  output logic [15:0] data_o,
  output logic        wr_act_o,
  output logic        ill_act_o,
  output logic        rd_start_o,
  output logic        rd_end_o,
  output logic        wr_start_o
);

  localparam int W = 22;
  // Cleared synchronizers hold every active-low strobe deasserted.
  localparam logic [W-1:0] IDLE_V = {4'b1111, 18'b0};

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_d [SYNC_STAGES];
  logic [W-1:0] last;
  logic         cs_n, rd_n, wr_n;
  logic         rd_act, wr_act;
  logic         rd_act_q, rd_act_d, wr_act_q, wr_act_d;

  always_comb begin
    sync_d[0] = {rst_n_i, cs_n_i, rd_n_i, wr_n_i, addr_i, data_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign last = sync_q[SYNC_STAGES-1];
  assign {rst_n_o, cs_n, rd_n, wr_n, addr_o, data_o} = last;

  assign rd_act    = ~cs_n & ~rd_n &  wr_n;
  assign wr_act    = ~cs_n & ~wr_n &  rd_n;
  assign ill_act_o = ~cs_n & ~rd_n & ~wr_n;
  assign wr_act_o  = wr_act;

  always_comb begin
    rd_act_d = rd_act;
    wr_act_d = wr_act;
  end

  assign rd_start_o = rising_edge(rd_act, rd_act_q);
  assign rd_end_o   = rising_edge(rd_act_q, rd_act);
  assign wr_start_o = rising_edge(wr_act, wr_act_q);

  // NOTE: clocked state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_V;
      rd_act_q <= 1'b0;
      wr_act_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      rd_act_q <= rd_act_d;
      wr_act_q <= wr_act_d;
    end
  end

endmodule

// File: rtl/hpi_responder.sv
// CY7C67200 HPI slave emulator: word RAM, mailbox pair and STATUS register.
// Define HPI_RESP_ERRCNT_EN to add the err_count illegal-strobe counter.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  input  logic [15:0] OTG_DATA_IN,
  output logic [15:0] OTG_DATA_OUT,
  output logic        OTG_DATA_OE,
  output logic        OTG_INT,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
`ifdef HPI_RESP_ERRCNT_EN
  output logic [7:0]  err_count,
`endif
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack
);

  logic        rst_n_s, wr_act, ill_act, rd_start, rd_end, wr_start;
  logic [1:0]  addr_s;
  logic [15:0] data_s;
  hpi_reg_e    sel;

  hpi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (Clk),
    .rst        (Reset),
    .cs_n_i     (OTG_CS_N),
    .rd_n_i     (OTG_RD_N),
    .wr_n_i     (OTG_WR_N),
    .rst_n_i    (OTG_RST_N),
    .addr_i     (OTG_ADDR),
    .data_i     (OTG_DATA_IN),
    .rst_n_o    (rst_n_s),
    .addr_o     (addr_s),
    .data_o     (data_s),
    .wr_act_o   (wr_act),
    .ill_act_o  (ill_act),
    .rd_start_o (rd_start),
    .rd_end_o   (rd_end),
    .wr_start_o (wr_start)
  );

  assign sel = hpi_reg_e'(addr_s);

  logic [15:0]       mem [2**MEM_AW];
  logic [MEM_AW-1:0] ram_idx;
  logic              ram_we;

  hpi_state_e  state_q, state_d;
  hpi_reg_e    reg_q, reg_d;
  logic [15:0] addr_q, addr_d, dout_q, dout_d, out_q, out_d, in_data_q, in_data_d;
  logic        oe_q, oe_d, full_q, full_d, in_valid_q, in_valid_d;

  assign ram_idx = addr_q[MEM_AW:1];

`ifdef HPI_RESP_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic       ill_prev_q, ill_prev_d;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q, so no path through this block infers a latch.
    state_d    = state_q;
    reg_d      = reg_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    out_d      = out_q;
    full_d     = full_q;
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    ram_we     = 1'b0;
`ifdef HPI_RESP_ERRCNT_EN
    err_d      = err_q;
    ill_prev_d = ill_act;
`endif
    if (!rst_n_s) begin
      state_d    = ST_IDLE;
      reg_d      = HPI_DATA;
      addr_d     = '0;
      dout_d     = '0;
      oe_d       = 1'b0;
      out_d      = '0;
      full_d     = 1'b0;
      in_data_d  = '0;
      in_valid_d = 1'b0;
`ifdef HPI_RESP_ERRCNT_EN
      err_d      = '0;
`endif
    end else begin
      // Ack is applied first so a same-cycle host mailbox write overrides it.
      if (mbx_in_ack) in_valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rd_start) begin
            state_d = ST_READ;
            reg_d   = sel;
            oe_d    = 1'b1;
            case (sel)
              HPI_DATA:    dout_d = mem[ram_idx];
              HPI_MAILBOX: dout_d = out_q;
              HPI_ADDRESS: dout_d = addr_q;
              HPI_STATUS:  dout_d = status_word(in_valid_q, full_q);
            endcase
          end else if (wr_start) begin
            state_d = ST_WRITE_DONE;
            case (sel)
              HPI_DATA: begin
                ram_we = 1'b1;
                addr_d = addr_q + 16'd2;
              end
              HPI_MAILBOX: begin
                in_data_d  = data_s;
                in_valid_d = 1'b1;
              end
              HPI_ADDRESS: addr_d = data_s;
              HPI_STATUS:  ;
            endcase
          end
        end
        ST_READ: begin
          if (rd_end && !ill_act) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            if (reg_q == HPI_DATA)    addr_d = addr_q + 16'd2;
            if (reg_q == HPI_MAILBOX) full_d = 1'b0;
          end
        end
        ST_WRITE_DONE: if (!wr_act && !ill_act) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // A fresh side-port message beats a same-cycle host mailbox read.
      if (mbx_out_wr) begin
        out_d  = mbx_out_data;
        full_d = 1'b1;
      end
`ifdef HPI_RESP_ERRCNT_EN
      if (rising_edge(ill_act, ill_prev_q) && err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      reg_q      <= HPI_DATA;
      addr_q     <= '0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
      out_q      <= '0;
      full_q     <= 1'b0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
`ifdef HPI_RESP_ERRCNT_EN
      err_q      <= '0;
      ill_prev_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      reg_q      <= reg_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      full_q     <= full_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
`ifdef HPI_RESP_ERRCNT_EN
      err_q      <= err_d;
      ill_prev_q <= ill_prev_d;
`endif
    end
  end

  // NOTE: RAM has no reset so it maps onto block/distributed memory; contents start undefined.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[ram_idx] <= data_s;
  end

  assign OTG_DATA_OUT = dout_q;
  assign OTG_DATA_OE  = oe_q;
  assign OTG_INT      = full_q;
  assign mbx_in_data  = in_data_q;
  assign mbx_in_valid = in_valid_q;
`ifdef HPI_RESP_ERRCNT_EN
  assign err_count    = err_q;
`endif

endmodule
